// File: rtl/ureg_pkg.sv
// Shared definitions for the ureg_cell universal register: mode encodings and widths.
package ureg_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROTL = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROTR = 3'b101;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/ureg_next.sv
// Combinational next-state function of the universal register: computes next q and carry
// from the current word, the selected mode and the serial/parallel inputs.
module ureg_next
  import ureg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]  q_i,
  input  logic              carry_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  d_i,
  input  logic              sin_l_i,
  input  logic              sin_r_i,
  output logic [WIDTH-1:0]  q_o,
  output logic              carry_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(32'd1);

  // Shifts are built from shift operators so that WIDTH = 1 needs no special slicing.
  logic [WIDTH-1:0] shl_s, shr_s, rotl_s, rotr_s;

  assign shl_s  = (q_i << 1'b1) | WIDTH'(sin_r_i);
  assign shr_s  = (q_i >> 1'b1) | (WIDTH'(sin_l_i) << (WIDTH - 1));
  assign rotl_s = (q_i << 1'b1) | WIDTH'(q_i[WIDTH-1]);
  assign rotr_s = (q_i >> 1'b1) | (WIDTH'(q_i[0]) << (WIDTH - 1));

  // Mode decode; unknown modes behave as HOLD.
  always_comb begin
    q_o     = q_i;
    carry_o = carry_i;
    case (mode_i)
      MODE_HOLD: begin q_o = q_i;       carry_o = carry_i;        end
      MODE_LOAD: begin q_o = d_i;       carry_o = 1'b0;           end
      MODE_SHL:  begin q_o = shl_s;     carry_o = q_i[WIDTH-1];   end
      MODE_SHR:  begin q_o = shr_s;     carry_o = q_i[0];         end
      MODE_ROTL: begin q_o = rotl_s;    carry_o = q_i[WIDTH-1];   end
      MODE_ROTR: begin q_o = rotr_s;    carry_o = q_i[0];         end
      MODE_INC:  begin q_o = q_i + ONE; carry_o = &q_i;           end
      MODE_DEC:  begin q_o = q_i - ONE; carry_o = ~|q_i;          end
      default:   begin q_o = q_i;       carry_o = carry_i;        end
    endcase
  end

endmodule

// File: rtl/ureg_cell.sv
// Universal register cell: one WIDTH-bit word plus registered carry, eight modes, serial chaining.
// Optional synchronous clear input sclr is present when UREG_CELL_SYNC_CLR_EN is defined.
module ureg_cell
  import ureg_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_r,
  input  logic              sin_l,
`ifdef UREG_CELL_SYNC_CLR_EN
  input  logic              sclr,
`endif
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  notq,
  output logic              sout_l,
  output logic              sout_r,
  output logic              carry,
  output logic              zero
);

  localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] q_q, q_d, q_nxt_s;
  logic             carry_q, carry_d, carry_nxt_s;

  ureg_next #(.WIDTH(WIDTH)) u_next (
    .q_i     (q_q),
    .carry_i (carry_q),
    .mode_i  (mode),
    .d_i     (d),
    .sin_l_i (sin_l),
    .sin_r_i (sin_r),
    .q_o     (q_nxt_s),
    .carry_o (carry_nxt_s)
  );

  // Enable / clear gating of the next-state function.
  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
`ifdef UREG_CELL_SYNC_CLR_EN
    if (sclr) begin
      q_d     = '0;
      carry_d = 1'b0;
    end else if (en) begin
      q_d     = q_nxt_s;
      carry_d = carry_nxt_s;
    end else begin
      q_d     = q_q;
      carry_d = carry_q;
    end
`else
    if (en) begin
      q_d     = q_nxt_s;
      carry_d = carry_nxt_s;
    end else begin
      q_d     = q_q;
      carry_d = carry_q;
    end
`endif
  end

  // State flops with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= RST_Q;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
    end
  end

  assign q      = q_q;
  assign carry  = carry_q;
  assign notq   = ~q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign zero   = ~|q_q;

endmodule

// File: tb/tb_ureg_cell.sv
// Directed self-checking bench for ureg_cell (WIDTH=8 with RESET_VALUE=8'hA5, and WIDTH=1).
// Define UREG_CELL_SYNC_CLR_EN to also exercise the synchronous clear.
module tb_ureg_cell;
  import ureg_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic              en8, sinr8, sinl8;
  logic [MODE_W-1:0] mode8;
  logic [7:0]        d8, q8, notq8;
  logic              soutl8, soutr8, carry8, zero8;

  logic              en1, sinr1, sinl1;
  logic [MODE_W-1:0] mode1;
  logic [0:0]        d1, q1, notq1;
  logic              soutl1, soutr1, carry1, zero1;
`ifdef UREG_CELL_SYNC_CLR_EN
  logic              sclr8, sclr1;
`endif

  always #5 clk = ~clk;

  ureg_cell #(.WIDTH(8), .RESET_VALUE(32'hA5)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .mode(mode8), .d(d8), .sin_r(sinr8), .sin_l(sinl8),
`ifdef UREG_CELL_SYNC_CLR_EN
    .sclr(sclr8),
`endif
    .q(q8), .notq(notq8), .sout_l(soutl8), .sout_r(soutr8), .carry(carry8), .zero(zero8)
  );

  ureg_cell #(.WIDTH(1), .RESET_VALUE(32'd0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .d(d1), .sin_r(sinr1), .sin_l(sinl1),
`ifdef UREG_CELL_SYNC_CLR_EN
    .sclr(sclr1),
`endif
    .q(q1), .notq(notq1), .sout_l(soutl1), .sout_r(soutr1), .carry(carry1), .zero(zero1)
  );

  // One clock on the 8-bit cell; outputs are sampled 1 time unit after the edge.
  task automatic op8(input logic e, input logic [MODE_W-1:0] m, input logic [7:0] dv,
                     input logic sr, input logic sl);
    en8 = e; mode8 = m; d8 = dv; sinr8 = sr; sinl8 = sl;
    @(posedge clk); #1;
  endtask

  task automatic op1(input logic e, input logic [MODE_W-1:0] m, input logic sr, input logic sl);
    en1 = e; mode1 = m; d1 = 1'b0; sinr1 = sr; sinl1 = sl;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (q8 !== 8'hA5) begin errors++; $display("FAIL reset_q got %h exp a5", q8); end
    checks++; if (carry8 !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", carry8); end
    checks++; if (zero8 !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", zero8); end
    checks++; if (notq8 !== 8'h5A) begin errors++; $display("FAIL reset_notq got %h exp 5a", notq8); end
    @(negedge clk); rst_n = 1'b1;
    op8(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
    op8(1'b1, MODE_INC, 8'h00, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h00 || carry8 !== 1'b1) begin errors++;
      $display("FAIL pre_reset_inc got q=%h c=%b exp q=00 c=1", q8, carry8); end
    // Reset mid-cycle while still counting: must take effect without an edge.
    #3 rst_n = 1'b0;
    #1;
    checks++; if (q8 !== 8'hA5 || carry8 !== 1'b0 || zero8 !== 1'b0) begin errors++;
      $display("FAIL async_reset got q=%h c=%b z=%b exp q=a5 c=0 z=0", q8, carry8, zero8); end
    @(posedge clk); #1;
    checks++; if (q8 !== 8'hA5) begin errors++; $display("FAIL reset_held got %h exp a5", q8); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_shift;
    op8(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h81 || carry8 !== 1'b0) begin errors++;
      $display("FAIL load got q=%h c=%b exp q=81 c=0", q8, carry8); end
    checks++; if (soutl8 !== 1'b1 || soutr8 !== 1'b1) begin errors++;
      $display("FAIL sout got l=%b r=%b exp l=1 r=1", soutl8, soutr8); end
    op8(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1);
    checks++; if (q8 !== 8'h02 || carry8 !== 1'b1) begin errors++;
      $display("FAIL shl got q=%h c=%b exp q=02 c=1", q8, carry8); end
    op8(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
    checks++; if (q8 !== 8'h81 || carry8 !== 1'b0) begin errors++;
      $display("FAIL shr got q=%h c=%b exp q=81 c=0", q8, carry8); end
    op8(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
    checks++; if (q8 !== 8'h03 || carry8 !== 1'b1) begin errors++;
      $display("FAIL shl_sin1 got q=%h c=%b exp q=03 c=1", q8, carry8); end
  endtask

  task automatic test_rotate;
    op8(1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0);
    op8(1'b1, MODE_ROTR, 8'h00, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h80 || carry8 !== 1'b1) begin errors++;
      $display("FAIL rotr got q=%h c=%b exp q=80 c=1", q8, carry8); end
    op8(1'b1, MODE_ROTL, 8'h00, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h01 || carry8 !== 1'b1) begin errors++;
      $display("FAIL rotl got q=%h c=%b exp q=01 c=1", q8, carry8); end
    op8(1'b1, MODE_ROTL, 8'h00, 1'b1, 1'b1);
    checks++; if (q8 !== 8'h02 || carry8 !== 1'b0) begin errors++;
      $display("FAIL rotl2 got q=%h c=%b exp q=02 c=0", q8, carry8); end
  endtask

  task automatic test_counter_wrap;
    op8(1'b1, MODE_LOAD, 8'hFE, 1'b0, 1'b0);
    op8(1'b1, MODE_INC, 8'h00, 1'b0, 1'b0);
    checks++; if (q8 !== 8'hFF || carry8 !== 1'b0 || zero8 !== 1'b0) begin errors++;
      $display("FAIL inc1 got q=%h c=%b z=%b exp q=ff c=0 z=0", q8, carry8, zero8); end
    op8(1'b1, MODE_INC, 8'h00, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h00 || carry8 !== 1'b1 || zero8 !== 1'b1) begin errors++;
      $display("FAIL inc_wrap got q=%h c=%b z=%b exp q=00 c=1 z=1", q8, carry8, zero8); end
    op8(1'b1, MODE_DEC, 8'h00, 1'b0, 1'b0);
    checks++; if (q8 !== 8'hFF || carry8 !== 1'b1) begin errors++;
      $display("FAIL dec_wrap got q=%h c=%b exp q=ff c=1", q8, carry8); end
    op8(1'b1, MODE_DEC, 8'h00, 1'b0, 1'b0);
    checks++; if (q8 !== 8'hFE || carry8 !== 1'b0) begin errors++;
      $display("FAIL dec got q=%h c=%b exp q=fe c=0", q8, carry8); end
  endtask

  task automatic test_hold;
    op8(1'b1, MODE_LOAD, 8'h9E, 1'b0, 1'b0);
    op8(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h3C || carry8 !== 1'b1) begin errors++;
      $display("FAIL hold_setup got q=%h c=%b exp q=3c c=1", q8, carry8); end
    for (int i = 0; i < 5; i++) begin
      op8(1'b0, MODE_INC, 8'h55, 1'b1, 1'b1);
      checks++; if (q8 !== 8'h3C || carry8 !== 1'b1) begin errors++;
        $display("FAIL en0_hold cyc%0d got q=%h c=%b exp q=3c c=1", i, q8, carry8); end
    end
    op8(1'b1, MODE_HOLD, 8'h55, 1'b1, 1'b1);
    checks++; if (q8 !== 8'h3C || carry8 !== 1'b1) begin errors++;
      $display("FAIL mode_hold got q=%h c=%b exp q=3c c=1", q8, carry8); end
  endtask

  task automatic test_width1;
    op1(1'b1, MODE_SHL, 1'b1, 1'b0);
    checks++; if (q1 !== 1'b1 || carry1 !== 1'b0) begin errors++;
      $display("FAIL w1_shl got q=%b c=%b exp q=1 c=0", q1, carry1); end
    op1(1'b1, MODE_SHR, 1'b1, 1'b0);
    checks++; if (q1 !== 1'b0 || carry1 !== 1'b1) begin errors++;
      $display("FAIL w1_shr got q=%b c=%b exp q=0 c=1", q1, carry1); end
    op1(1'b1, MODE_INC, 1'b0, 1'b0);
    checks++; if (q1 !== 1'b1 || carry1 !== 1'b0 || zero1 !== 1'b0) begin errors++;
      $display("FAIL w1_inc01 got q=%b c=%b z=%b exp q=1 c=0 z=0", q1, carry1, zero1); end
    op1(1'b1, MODE_ROTL, 1'b0, 1'b0);
    checks++; if (q1 !== 1'b1 || carry1 !== 1'b1) begin errors++;
      $display("FAIL w1_rotl got q=%b c=%b exp q=1 c=1", q1, carry1); end
    op1(1'b1, MODE_INC, 1'b0, 1'b0);
    checks++; if (q1 !== 1'b0 || carry1 !== 1'b1 || zero1 !== 1'b1) begin errors++;
      $display("FAIL w1_inc10 got q=%b c=%b z=%b exp q=0 c=1 z=1", q1, carry1, zero1); end
    op1(1'b1, MODE_DEC, 1'b0, 1'b0);
    checks++; if (q1 !== 1'b1 || carry1 !== 1'b1) begin errors++;
      $display("FAIL w1_dec got q=%b c=%b exp q=1 c=1", q1, carry1); end
    op1(1'b0, MODE_HOLD, 1'b0, 1'b0);
  endtask

`ifdef UREG_CELL_SYNC_CLR_EN
  task automatic test_sclr;
    op8(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
    op8(1'b1, MODE_INC, 8'h00, 1'b0, 1'b0);
    op8(1'b1, MODE_LOAD, 8'h7F, 1'b0, 1'b0);
    checks++; if (q8 !== 8'h7F) begin errors++; $display("FAIL sclr_setup got %h exp 7f", q8); end
    sclr8 = 1'b1;
    op8(1'b1, MODE_LOAD, 8'h55, 1'b0, 1'b0);
    sclr8 = 1'b0;
    checks++; if (q8 !== 8'h00 || carry8 !== 1'b0) begin errors++;
      $display("FAIL sclr got q=%h c=%b exp q=00 c=0", q8, carry8); end
  endtask
`endif

  initial begin
    en8 = 1'b0; mode8 = MODE_HOLD; d8 = 8'h00; sinr8 = 1'b0; sinl8 = 1'b0;
    en1 = 1'b0; mode1 = MODE_HOLD; d1 = 1'b0; sinr1 = 1'b0; sinl1 = 1'b0;
`ifdef UREG_CELL_SYNC_CLR_EN
    sclr8 = 1'b0; sclr1 = 1'b0;
`endif
    test_reset();
    test_load_shift();
    test_rotate();
    test_counter_wrap();
    test_hold();
    test_width1();
`ifdef UREG_CELL_SYNC_CLR_EN
    test_sclr();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
